// File: rtl/padd9_seq_pkg.sv
// Shared types for the PADD9 chain sequencer: command opcodes, FSM states
// and the latency ceiling of the pre-adder pipeline.
package padd9_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  localparam int unsigned LAT_MAX = 7;

endpackage

// File: rtl/padd9_chain_seq.sv
// Sequencer for a cascaded PADD9 pre-adder chain: clears the chain, shifts
// B coefficients in through the tail stage, then broadcasts A samples.
module padd9_chain_seq
  import padd9_seq_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int W      = 9,
  parameter int LAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NSTAGE*W-1:0]   res_data,
  output logic                  padd_ce,
  output logic                  padd_rst,
  output logic [W-1:0]          padd_a,
  output logic [W-1:0]          padd_b,
  input  logic [NSTAGE*W-1:0]   padd_dout,
  output logic                  busy,
  output logic                  err
);

  localparam int SC_W = $clog2(NSTAGE + 1);
  localparam logic [SC_W-1:0]  STG_INIT = SC_W'(NSTAGE);
  localparam logic [SC_W-1:0]  STG_ONE  = SC_W'(1);
  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] REM_ZERO = CNT_W'(0);
  localparam logic [2:0]       LAT_INIT = 3'(LAT);

  state_e              state_r, state_s;
  logic [SC_W-1:0]     stg_r, stg_s;
  logic [CNT_W-1:0]    rem_r, rem_s;
  logic [2:0]          lat_r, lat_s;
  logic                ce_s, rst_s, rv_s, err_s;
  logic [W-1:0]        a_s, b_s;
  logic [NSTAGE*W-1:0] rd_s;

  assign cmd_ready = (state_r == ST_IDLE);
  assign in_ready  = (state_r == ST_LOAD) || (state_r == ST_ISSUE);
  assign busy      = (state_r != ST_IDLE);

  // Next-state and next-output decode; CE is a one-cycle pulse unless CLR holds it.
  always_comb begin
    state_s = state_r;
    stg_s   = stg_r;
    rem_s   = rem_r;
    lat_s   = lat_r;
    ce_s    = 1'b0;
    rst_s   = 1'b0;
    a_s     = padd_a;
    b_s     = padd_b;
    rv_s    = res_valid;
    rd_s    = res_data;
    err_s   = err;
    case (state_r)
      ST_CLR: begin
        if (stg_r <= STG_ONE) begin
          state_s = ST_IDLE;
          stg_s   = '0;
        end else begin
          ce_s    = 1'b1;
          rst_s   = 1'b1;
          stg_s   = stg_r - STG_ONE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_CLEAR: begin
              state_s = ST_CLR;
              stg_s   = STG_INIT;
              ce_s    = 1'b1;
              rst_s   = 1'b1;
            end
            OP_LOAD: begin
              state_s = ST_LOAD;
              stg_s   = STG_INIT;
            end
            OP_RUN: begin
              if (cmd_len != REM_ZERO) begin
                state_s = ST_ISSUE;
                rem_s   = cmd_len;
              end else begin
                state_s = ST_IDLE;
              end
            end
            OP_RSVD: err_s = 1'b1;
            default: err_s = 1'b1;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          b_s  = in_data;
          ce_s = 1'b1;
          if (stg_r <= STG_ONE) begin
            state_s = ST_IDLE;
            stg_s   = '0;
          end else begin
            stg_s   = stg_r - STG_ONE;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        if (in_valid) begin
          a_s     = in_data;
          lat_s   = LAT_INIT;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // Capture only once padd_dout reflects the new padd_a.
        if (lat_r == 3'd0) begin
          rd_s    = padd_dout;
          rv_s    = 1'b1;
          state_s = ST_HOLD;
        end else begin
          lat_s   = lat_r - 3'd1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          rv_s  = 1'b0;
          rem_s = rem_r - REM_ONE;
          if (rem_r > REM_ONE) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_CLR;
        stg_s   = STG_INIT;
        ce_s    = 1'b1;
        rst_s   = 1'b1;
      end
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_CLR;
      stg_r     <= STG_INIT;
      rem_r     <= '0;
      lat_r     <= 3'd0;
      padd_ce   <= 1'b1;
      padd_rst  <= 1'b1;
      padd_a    <= '0;
      padd_b    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      stg_r     <= stg_s;
      rem_r     <= rem_s;
      lat_r     <= lat_s;
      padd_ce   <= ce_s;
      padd_rst  <= rst_s;
      padd_a    <= a_s;
      padd_b    <= b_s;
      res_valid <= rv_s;
      res_data  <= rd_s;
      err       <= err_s;
    end
  end

endmodule
